// File: rtl/sisc_pkg.sv
// sisc_pkg: shared SISC opcodes, IR field positions, status bit indices and fetch FSM states.
package sisc_pkg;
    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_HLT  = 4'd15;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int STAT_C = 3;
    localparam int STAT_N = 2;
    localparam int STAT_Z = 1;
    localparam int STAT_V = 0;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;
    function automatic logic is_rel(input logic [3:0] op);
        return op == OP_BRR || op == OP_BNR;
    endfunction
endpackage

// File: rtl/sisc_br_eval.sv
// sisc_br_eval: combinational branch resolution for BRA/BRR/BNE/BNR.
module sisc_br_eval
    import sisc_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [3:0]        mm,
    input  logic [3:0]        stat,
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       imm,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);
    logic              hit;
    logic [ADDR_W+15:0] imm_s, imm_z;
    always_comb begin
        hit    = |(stat & mm);
        imm_s  = {{ADDR_W{imm[15]}}, imm};
        imm_z  = {{ADDR_W{1'b0}}, imm};
        taken  = ((opcode == OP_BRA || opcode == OP_BRR) && hit) ||
                 ((opcode == OP_BNE || opcode == OP_BNR) && !hit);
        // relative targets wrap modulo 2^ADDR_W through the truncating cast
        target = ADDR_W'(is_rel(opcode) ? {16'b0, pc} + imm_s : imm_z);
    end
endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: SISC fetch/branch stage holding PC, IR and status register.
// Define SISC_FETCH_TIMEOUT_EN to abort stalled fetches with a sticky fetch_err.
module sisc_ifetch
    import sisc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_go,
    input  logic              br_go,
    input  logic              stat_en,
    input  logic [3:0]        alu_stat,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [3:0]        stat,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);
    logic [0:0]        state;
    logic [ADDR_W-1:0] pc, target;
    logic              taken;
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 4-bit wait counter");
    end
    assign imem_req  = state == ST_REQ;
    assign busy      = state == ST_REQ;
    assign imem_addr = pc;
    assign opcode    = ir[OPC_HI:OPC_LO];
    assign mm        = ir[MM_HI:MM_LO];
    sisc_br_eval #(.ADDR_W(ADDR_W)) u_br (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .pc     (pc),
        .imm    (ir[IMM_HI:IMM_LO]),
        .taken  (taken),
        .target (target)
    );
`ifdef SISC_FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt;
`else
    assign fetch_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            stat     <= '0;
            ir_valid <= 1'b0;
`ifdef SISC_FETCH_TIMEOUT_EN
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
`endif
        end else begin
            ir_valid <= 1'b0;
            if (stat_en) stat <= alu_stat;
            if (state == ST_IDLE) begin
                // branch lands first so a same-cycle fetch uses the new PC
                if (br_go && taken) pc <= target;
                if (fetch_go) begin
                    state <= ST_REQ;
`ifdef SISC_FETCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
            end else if (imem_ready) begin
                ir       <= imem_rdata;
                pc       <= pc + ADDR_W'(1);
                ir_valid <= 1'b1;
                state    <= ST_IDLE;
            end
`ifdef SISC_FETCH_TIMEOUT_EN
            else if (wait_cnt == 4'(TIMEOUT_CYC - 1)) begin
                fetch_err <= 1'b1;
                ir        <= {OP_NOOP, 28'b0};
                ir_valid  <= 1'b1;
                state     <= ST_IDLE;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: random + directed bench for sisc_ifetch against a transaction-level model.
module tb_sisc_ifetch;
`ifdef SISC_FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 15;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        fetch_go = 1'b0, br_go = 1'b0, stat_en = 1'b0, imem_ready = 1'b0;
    logic [3:0]  alu_stat = '0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, ir_valid, busy, fetch_err;
    logic [15:0] imem_addr;
    logic [31:0] ir;
    logic [3:0]  opcode, mm, stat;

    sisc_ifetch #(.ADDR_W(16), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .br_go(br_go),
        .stat_en(stat_en), .alu_stat(alu_stat), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .ir(ir), .opcode(opcode), .mm(mm), .stat(stat), .ir_valid(ir_valid),
        .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] mem [256];
    int          m_pc, m_stat, m_wait;
    logic [31:0] m_ir;
    bit          m_req, m_valid, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Next PC after evaluating the branch held in w, from the ISA rules.
    function automatic int br_next(input logic [31:0] w, input int st, input int pc);
        int  op   = int'(w[31:28]);
        int  mmv  = int'(w[27:24]);
        int  imm  = int'(w[15:0]);
        int  simm = imm >= 32768 ? imm - 65536 : imm;
        bit  hit  = (st & mmv) != 0;
        int  rel  = (pc + simm + 65536) % 65536;
        case (op)
            4: return hit ? imm : pc;
            5: return hit ? rel : pc;
            6: return !hit ? imm : pc;
            7: return !hit ? rel : pc;
            default: return pc;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = '0; m_stat = 0; m_req = 0; m_valid = 0; m_err = 0; m_wait = 0;
    endtask

    task automatic model_edge(input bit fg, bg, se, input int as, input bit rdy, input logic [31:0] rd);
        bit nv = 0;
        if (!m_req) begin
            if (bg) m_pc = br_next(m_ir, m_stat, m_pc);
            if (fg) begin m_req = 1; m_wait = 0; end
        end else if (rdy) begin
            m_ir = rd; m_pc = (m_pc + 1) % 65536; nv = 1; m_req = 0;
        end else begin
            m_wait++;
            if (TO_EN && m_wait == TO_CYC) begin m_err = 1; m_ir = '0; nv = 1; m_req = 0; end
        end
        if (se) m_stat = as;
        m_valid = nv;
    endtask

    task automatic step(input bit fg, bg, se, input logic [3:0] as, input bit rdy);
        fetch_go = fg; br_go = bg; stat_en = se; alu_stat = as; imem_ready = rdy;
        imem_rdata = rdy ? mem[m_pc & 255] : $urandom;
        @(posedge clk);
        model_edge(fg, bg, se, int'(as), rdy, imem_rdata);
        @(negedge clk);
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        chk("busy", {31'b0, busy}, {31'b0, m_req});
        chk("imem_addr", {16'b0, imem_addr}, m_pc);
        chk("ir", ir, m_ir);
        chk("opcode", {28'b0, opcode}, {28'b0, m_ir[31:28]});
        chk("mm", {28'b0, mm}, {28'b0, m_ir[27:24]});
        chk("stat", {28'b0, stat}, m_stat);
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
        chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    endtask

    task automatic fetch_word(input logic [31:0] w);
        mem[m_pc & 255] = w;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
    endtask

    initial begin
        int nb;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_addr", {16'b0, imem_addr}, 0);
        chk("rst_ir", ir, 0);
        chk("rst_stat", {28'b0, stat}, 0);
        chk("rst_valid", {31'b0, ir_valid}, 0);
        chk("rst_err", {31'b0, fetch_err}, 0);
        rst_f = 1'b1;
        // zero-wait fetch of word 0
        mem[0] = 32'h1000_0000;
        step(1, 0, 0, 0, 0);
        chk("zw_req_c1", {31'b0, imem_req}, 1);
        chk("zw_addr_c1", {16'b0, imem_addr}, 0);
        step(0, 0, 0, 0, 1);
        chk("zw_valid_c2", {31'b0, ir_valid}, 1);
        chk("zw_opcode", {28'b0, opcode}, 1);
        chk("zw_pc", {16'b0, imem_addr}, 1);
        // three wait states, extra fetch_go/br_go during REQ
        nb = 0;
        step(1, 0, 0, 0, 0); nb += int'(busy);
        step(1, 0, 0, 0, 0); nb += int'(busy);
        step(0, 1, 0, 0, 0); nb += int'(busy);
        step(0, 0, 0, 0, 0); nb += int'(busy);
        step(0, 0, 0, 0, 1);
        chk("ws_busy_cycles", nb, 4);
        chk("ws_valid_c5", {31'b0, ir_valid}, 1);
        chk("ws_busy_c5", {31'b0, busy}, 0);
        chk("ws_pc", {16'b0, imem_addr}, 2);
        // branches
        step(0, 0, 1, 4'b0001, 0);
        fetch_word(32'h4100_0020);
        step(0, 1, 0, 0, 0);
        chk("bra_pc", {16'b0, imem_addr}, 32'h20);
        fetch_word(32'h6100_0020);
        step(0, 1, 0, 0, 0);
        chk("bne_not_taken", {16'b0, imem_addr}, 32'h21);
        fetch_word(32'h4100_0004);
        step(0, 1, 0, 0, 0);
        fetch_word(32'h51FF_FFFE);
        chk("brr_pre_pc", {16'b0, imem_addr}, 5);
        step(0, 1, 0, 0, 0);
        chk("brr_pc", {16'b0, imem_addr}, 3);
        fetch_word(32'h4100_FFFE);
        step(0, 1, 0, 0, 0);
        fetch_word(32'h5100_0002);
        chk("pre_wrap_pc", {16'b0, imem_addr}, 32'hFFFF);
        step(0, 1, 0, 0, 0);
        chk("brr_wrap_pc", {16'b0, imem_addr}, 1);
        fetch_word(32'h4100_FFFF);
        step(0, 1, 0, 0, 0);
        fetch_word(32'h0000_0000);
        chk("pc_inc_wrap", {16'b0, imem_addr}, 0);
        // branch and fetch together
        fetch_word(32'h4100_0040);
        step(1, 1, 0, 0, 0);
        chk("brfetch_addr", {16'b0, imem_addr}, 32'h40);
        chk("brfetch_req", {31'b0, imem_req}, 1);
        step(0, 0, 0, 0, 1);
        // stat load alongside branch: old stat=1 makes BNE mm=2 taken
        fetch_word(32'h6200_0080);
        step(0, 1, 1, 4'hF, 0);
        chk("old_stat_branch", {16'b0, imem_addr}, 32'h80);
        chk("stat_loaded", {28'b0, stat}, 32'hF);
        // reset mid-fetch, late ready ignored
        fetch_word(32'h3300_0000);
        step(1, 0, 0, 0, 0);
        #2 rst_f = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 0);
        chk("mid_rst_pc", {16'b0, imem_addr}, 0);
        chk("mid_rst_ir", ir, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_f = 1'b1;
        step(0, 0, 0, 0, 1);
        chk("late_ready_valid", {31'b0, ir_valid}, 0);
        chk("late_ready_ir", ir, 0);
`ifdef SISC_FETCH_TIMEOUT_EN
        fetch_word(32'h1234_5678);
        step(1, 0, 0, 0, 0);
        repeat (14) step(0, 0, 0, 0, 0);
        chk("to_busy_15", {31'b0, busy}, 1);
        chk("to_err_early", {31'b0, fetch_err}, 0);
        step(0, 0, 0, 0, 0);
        chk("to_err", {31'b0, fetch_err}, 1);
        chk("to_ir", ir, 0);
        chk("to_valid", {31'b0, ir_valid}, 1);
        chk("to_busy", {31'b0, busy}, 0);
        chk("to_pc", {16'b0, imem_addr}, 1);
        fetch_word(32'h2000_0000);
        chk("to_err_sticky", {31'b0, fetch_err}, 1);
        #2 rst_f = 1'b0;
        #1 chk("to_err_rst", {31'b0, fetch_err}, 0);
        model_reset();
        @(negedge clk);
        rst_f = 1'b1;
`endif
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 4'($urandom), $urandom_range(0, 2) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sisc_ifetch.md
# sisc_ifetch

Instruction-fetch and branch stage of the SISC computer. It sits directly upstream of the control FSM and holds the program counter (PC), instruction register (IR) and status register. It fetches 32-bit words from instruction memory through a wait-state-capable request/ready handshake. It resolves BRA/BRR/BNE/BNR targets and feeds `opcode`, `mm` and `stat` to the control FSM.

## Interface
- `ADDR_W`, 16: PC and instruction-memory address width.
- `TIMEOUT_CYC`, 15: maximum wait cycles per fetch. Used only with `SISC_FETCH_TIMEOUT_EN`.
- `clk`  in  1: single clock, rising edge.
- `rst_f`  in  1: reset, asynchronous, active-low.
- `fetch_go`  in  1: one-cycle pulse from the control FSM; starts a fetch.
- `br_go`  in  1: one-cycle pulse; evaluate the branch held in IR.
- `stat_en`  in  1: load `alu_stat` into the status register.
- `alu_stat`  in  4: ALU flags {C,N,Z,V} (bit 3..0).
- `imem_req`  out  1: memory request.
- `imem_addr`  out  ADDR_W: word address; equals PC.
- `imem_rdata`  in  32: instruction word; valid when `imem_ready` is high.
- `imem_ready`  in  1: data-valid strobe. Sampled only while `imem_req` is high.
- `ir`  out  32: instruction register.
- `opcode`  out  4: `ir[31:28]`.
- `mm`  out  4: `ir[27:24]`.
- `stat`  out  4: status register.
- `ir_valid`  out  1: one-cycle pulse; new IR contents are available.
- `busy`  out  1: high while in REQ.
- `fetch_err`  out  1: sticky timeout flag.

## Operation
- Reset (`rst_f` low, any state, including mid-fetch): PC=0, IR=0, stat=0, state=IDLE.
  - All strobes low: `imem_req`, `ir_valid`, `busy`, `fetch_err`.
  - An in-flight memory response is discarded.
- FSM has two states.
  - IDLE: on `fetch_go`, go to REQ.
  - REQ: `imem_req`=1, `busy`=1, `imem_addr`=PC. On `imem_ready`: IR←`imem_rdata`, PC←PC+1 (wraps at 2^ADDR_W−1 → 0), pulse `ir_valid` next cycle, go to IDLE.
- `fetch_go` while in REQ is ignored.
- Branch, on `br_go` in IDLE, using `opcode` from IR and `imm`=`ir[15:0]`:
  - Condition: `hit` = |(`stat` & `mm`).
  - Taken: BRA/BRR when `hit`=1; BNE/BNR when `hit`=0.
  - BRA/BNE (absolute): PC←`imm[ADDR_W-1:0]`.
  - BRR/BNR (relative): PC←PC + sign-extended `imm`, modulo 2^ADDR_W. PC is already incremented at this point.
  - Not taken, or any other opcode: PC unchanged.
  - `br_go` in REQ is ignored.
- `br_go` and `fetch_go` in the same IDLE cycle: the branch updates PC at that edge, and the fetch enters REQ using the updated PC.
- `stat_en`: stat←`alu_stat` at the edge. It is independent of FSM state. A branch evaluated in the same cycle uses the old `stat`.

## Timing
- Zero-wait fetch:
  - `fetch_go` at cycle 0.
  - `imem_req` high in cycle 1; `imem_ready` high in cycle 1.
  - IR and PC updated at the end of cycle 1; `ir_valid` high in cycle 2.
- Each memory wait cycle adds one cycle of latency.
- `imem_req` stays high until the ready cycle. It deasserts in the cycle after `imem_ready`.
- All outputs are registered, except `opcode`/`mm` (wired from IR) and `imem_addr` (wired from PC).

## Configuration
- `SISC_FETCH_TIMEOUT_EN` defined:
  - A 4-bit wait counter clears on entry to REQ and increments each REQ cycle without `imem_ready`.
  - When it reaches `TIMEOUT_CYC`: `fetch_err`←1, IR←0 (NOOP), PC unchanged, go to IDLE, pulse `ir_valid`.
  - `fetch_err` clears only on reset.
- Not defined: REQ waits indefinitely, `fetch_err` is tied 0, and no counter logic exists.

## Structure
- Shared package `sisc_pkg` holds:
  - Opcode constants (NOOP=0 … HLT=15, including BRA=4, BRR=5, BNE=6, BNR=7).
  - IR field positions.
  - Status bit indices.
- Optional sub-module `sisc_br_eval` (combinational): inputs `opcode`, `mm`, `stat`, PC, `imm`; outputs `taken` and `target`. All sequential logic stays in `sisc_ifetch`.

## Test plan
- Reset then fetch:
  - Setup: memory word 0 = 0x1000_0000; `fetch_go` pulse, zero wait.
  - Required: `imem_addr`=0, `ir_valid` in cycle 2, `opcode`=1, PC=1.
- Wait states:
  - Setup: `imem_ready` delayed 3 cycles.
  - Required: `busy` high for 4 cycles, `ir_valid` in cycle 5; a second `fetch_go` during REQ has no effect.
- Branches:
  - stat=0b0001, IR=0x4100_0020 (BRA, mm=1), `br_go` → PC=0x20.
  - Same stat, IR=0x6100_0020 (BNE) → PC unchanged.
  - PC=5, IR=0x51FF_FFFE (BRR, mm=1, stat=0b0001) → PC=3.
  - PC=0xFFFF, relative +2 → PC=1.
- Simultaneous events:
  - `br_go` + `fetch_go` with BRA to 0x40 → `imem_addr`=0x40.
  - `stat_en` with `alu_stat`=0xF in the same cycle as `br_go` → branch uses the old stat.
- Reset mid-fetch:
  - `rst_f` low while in REQ → `imem_req` drops immediately; PC=0, IR=0.
  - A late `imem_ready` is ignored.
- With `SISC_FETCH_TIMEOUT_EN`:
  - Setup: `imem_ready` held low.
  - Required: after 15 REQ cycles, `fetch_err`=1, IR=0, `ir_valid` pulses; `fetch_err` stays set until reset.
